tx_dist_fifo: RTL and testbench
===============================

TX_DIST_FIFO -- requirements
Module: tx_dist_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, range 4..10; storage depth DEPTH = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 70, range 1..256; word width.
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = RAM read feeds m_data directly, 1 = one registered output stage.
REQ-004 SHALL have parameter AFULL_LVL, default DEPTH-2; almost_full threshold in entries.
REQ-005 SHALL have parameter AEMPTY_LVL, default 2; almost_empty threshold in entries.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 flush  input  1  synchronous clear of contents, active-high.
REQ-009 s_data  input  DATA_WIDTH  write word.
REQ-010 s_valid  input  1  write request.
REQ-011 s_ready  output  1  FIFO can accept; write occurs when s_valid && s_ready.
REQ-012 m_data  output  DATA_WIDTH  head word, valid when m_valid.
REQ-013 m_valid  output  1  head word present (first-word-fall-through).
REQ-014 m_ready  input  1  consumer accept; pop occurs when m_valid && m_ready.
REQ-015 level  output  ADDR_WIDTH+1  entries held, including the output stage.
REQ-016 almost_full  output  1  level >= AFULL_LVL.
REQ-017 almost_empty  output  1  level <= AEMPTY_LVL.
REQ-018 ovf_cnt  output  16  count of cycles with s_valid && !s_ready, saturating.

Function
REQ-019 Storage SHALL be a distributed simple dual-port RAM: synchronous write, asynchronous read, indexed by wr_ptr and rd_ptr of ADDR_WIDTH bits, each wrapping DEPTH-1 -> 0.
REQ-020 Full/empty SHALL be derived from pointers extended to ADDR_WIDTH+1 bits: equal MSB-differing = full, fully equal = empty.
REQ-021 Capacity SHALL be DEPTH with OUT_REG=0 and DEPTH+1 with OUT_REG=1.
REQ-022 s_ready SHALL be registered and deasserted exactly when the next-cycle level equals capacity.
REQ-023 OUT_REG=0: m_valid = !empty, m_data = RAM[rd_ptr]; write-to-m_valid latency 1 cycle.
REQ-024 OUT_REG=1: the output stage SHALL load from RAM when empty or popped and RAM is non-empty; write-to-m_valid latency 2 cycles; m_data changes only on load.
REQ-025 Simultaneous push and pop SHALL leave level unchanged, both pointers advancing.
REQ-026 Simultaneous push and pop when level=capacity SHALL be impossible by REQ-022; no write shall occur.
REQ-027 Push into an empty FIFO SHALL NOT bypass RAM; m_valid rises per REQ-023/REQ-024.
REQ-028 level, almost_full and almost_empty SHALL be registered and reflect the same cycle's pointer update.
REQ-029 m_data and m_valid SHALL hold stable while m_valid && !m_ready.
REQ-030 flush SHALL, on the next edge, zero pointers, level, output stage and ovf_cnt; a push or pop in the flush cycle SHALL be discarded.
REQ-031 ovf_cnt SHALL increment by 1 per cycle of s_valid && !s_ready and saturate at 16'hFFFF.

Reset
REQ-032 While rst is high: pointers=0, level=0, m_valid=0, s_ready=0, almost_full=0, almost_empty=1, ovf_cnt=0, output stage=0; RAM contents undefined.
REQ-033 s_ready SHALL rise on the first clk edge after rst deasserts.
REQ-034 rst asserted mid-transfer SHALL take effect immediately without waiting for clk; all in-flight words are lost.

Verification
REQ-035 Defaults, push 16 words 0..15 with m_ready=0 -> s_ready low after 16th push, level=16, almost_full=1 from level 14; pop all -> data 0..15 in order.
REQ-036 OUT_REG=1, push one word 0x2A at cycle t -> m_valid=1 and m_data=0x2A at t+2; fill -> 17 words accepted.
REQ-037 level=8, s_valid=m_valid=m_ready=1 for 40 cycles -> level stays 8, pointers wrap twice, output order preserved.
REQ-038 full FIFO, s_valid=1 for 5 cycles -> ovf_cnt=5, no data corruption; flush -> level=0, m_valid=0, ovf_cnt=0 next cycle.
REQ-039 rst pulse between clk edges while level=5 -> m_valid=0, level=0 immediately; s_ready=1 one edge after release.
REQ-040 Random push/pop, ADDR_WIDTH=10, DATA_WIDTH=256, 100k cycles -> scoreboard match, level equals model every cycle.

Source files
------------

// File: rtl/tx_dist_fifo.sv
// First-word-fall-through FIFO built on a distributed (async-read) dual-port RAM,
// with an optional registered output stage, registered level/threshold flags and an overflow counter.
module tx_dist_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 70,
    parameter int OUT_REG    = 0,
    parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [15:0]           ovf_cnt
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int CAPACITY = (OUT_REG != 0) ? DEPTH + 1 : DEPTH;
    localparam logic [ADDR_WIDTH:0] CAP     = CAPACITY[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic [15:0]         ovfCnt_q, ovfCnt_d;
    logic                sReady_q;
    logic                aFull_q;
    logic                aEmpty_q;

    logic                  ramEmpty;
    logic                  ramFull;
    logic                  push;
    logic                  pop;
    logic                  ramRead;
    logic [DATA_WIDTH-1:0] ramData;

    assign ramEmpty = (wrPtr_q == rdPtr_q);
    assign ramFull  = (wrPtr_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]) &&
                      (wrPtr_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]);
    assign ramData  = mem[rdPtr_q[ADDR_WIDTH-1:0]];
    assign push     = s_valid && sReady_q && !ramFull;

    // Storage has no reset; a write in the flush cycle is dropped along with the contents.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wrPtr_q[ADDR_WIDTH-1:0]] <= s_data;
        end
    end

    if (OUT_REG != 0) begin : gOutReg
        logic                  outValid_q;
        logic [DATA_WIDTH-1:0] outData_q;

        // The stage refills from RAM whenever it is empty or being drained this cycle.
        assign pop     = outValid_q && m_ready;
        assign ramRead = !ramEmpty && (!outValid_q || m_ready);
        assign m_valid = outValid_q;
        assign m_data  = outData_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                outValid_q <= 1'b0;
                outData_q  <= '0;
            end else if (flush) begin
                outValid_q <= 1'b0;
                outData_q  <= '0;
            end else if (ramRead) begin
                outValid_q <= 1'b1;
                outData_q  <= ramData;
            end else if (pop) begin
                outValid_q <= 1'b0;
            end
        end
    end else begin : gNoOutReg
        assign pop     = !ramEmpty && m_ready;
        assign ramRead = pop;
        assign m_valid = !ramEmpty;
        assign m_data  = ramData;
    end

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        level_d  = level_q;
        ovfCnt_d = ovfCnt_q;
        if (flush) begin
            wrPtr_d  = '0;
            rdPtr_d  = '0;
            level_d  = '0;
            ovfCnt_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (ramRead) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (push && !pop) begin
                level_d = level_q + PTR_ONE;
            end else if (pop && !push) begin
                level_d = level_q - PTR_ONE;
            end
            if (s_valid && !sReady_q && (ovfCnt_q != 16'hFFFF)) begin
                ovfCnt_d = ovfCnt_q + 16'd1;
            end
        end
    end

    // Flags are derived from the next level so they line up with the pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            level_q  <= '0;
            ovfCnt_q <= '0;
            sReady_q <= 1'b0;
            aFull_q  <= 1'b0;
            aEmpty_q <= 1'b1;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            level_q  <= level_d;
            ovfCnt_q <= ovfCnt_d;
            sReady_q <= (level_d != CAP);
            aFull_q  <= (int'(level_d) >= AFULL_LVL);
            aEmpty_q <= (int'(level_d) <= AEMPTY_LVL);
        end
    end

    assign s_ready      = sReady_q;
    assign level        = level_q;
    assign almost_full  = aFull_q;
    assign almost_empty = aEmpty_q;
    assign ovf_cnt      = ovfCnt_q;

endmodule

// File: tb/tb_tx_dist_fifo.sv
// Self-checking bench for tx_dist_fifo: two instances (direct read and registered output)
// share one stimulus stream and are compared every cycle against a queue-based model.
module tb_tx_dist_fifo;

    localparam int DW    = 70;
    localparam int AFULL = 14;
    localparam int AEMPT = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          flush   = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data  = '0;

    logic [1:0]    sReady;
    logic [1:0]    mValid;
    logic [1:0]    aFull;
    logic [1:0]    aEmpty;
    logic [DW-1:0] mData [2];
    logic [4:0]    lvl [2];
    logic [15:0]   ovf [2];

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    tx_dist_fifo dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(sReady[0]),
        .m_data(mData[0]), .m_valid(mValid[0]), .m_ready(m_ready),
        .level(lvl[0]), .almost_full(aFull[0]), .almost_empty(aEmpty[0]),
        .ovf_cnt(ovf[0])
    );

    tx_dist_fifo #(.OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(sReady[1]),
        .m_data(mData[1]), .m_valid(mValid[1]), .m_ready(m_ready),
        .level(lvl[1]), .almost_full(aFull[1]), .almost_empty(aEmpty[1]),
        .ovf_cnt(ovf[1])
    );

    always #5 clk = ~clk;

    // Model state: each instance is an ordered list of words stamped with the edge that wrote them.
    logic [DW-1:0] qData  [2][64];
    int            qStamp [2][64];
    int            qHead  [2];
    int            qCnt   [2];
    bit            mRdy   [2];
    int            mOvf   [2];
    int            cyc = 0;

    function automatic int capOf(input int i);
        return (i == 0) ? 16 : 17;
    endfunction

    // A word becomes visible one edge after its write, or two with the registered output stage.
    function automatic bit modelValid(input int i);
        if (qCnt[i] == 0) return 1'b0;
        return (cyc - qStamp[i][qHead[i]]) >= i;
    endfunction

    task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model on each clock edge using the inputs the DUTs see at that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                qHead[i] = 0;
                qCnt[i]  = 0;
                mRdy[i]  = 1'b0;
                mOvf[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit vis;
                bit pushOk;
                bit popOk;
                vis    = modelValid(i);
                pushOk = s_valid && mRdy[i];
                popOk  = vis && m_ready;
                if (flush) begin
                    qHead[i] = 0;
                    qCnt[i]  = 0;
                    mOvf[i]  = 0;
                end else begin
                    if (s_valid && !mRdy[i] && mOvf[i] != 65535) mOvf[i]++;
                    if (popOk) begin
                        qHead[i] = (qHead[i] + 1) % 64;
                        qCnt[i]--;
                    end
                    if (pushOk) begin
                        qData[i][(qHead[i] + qCnt[i]) % 64]  = s_data;
                        qStamp[i][(qHead[i] + qCnt[i]) % 64] = cyc + 1;
                        qCnt[i]++;
                    end
                end
                mRdy[i] = (qCnt[i] != capOf(i));
            end
            cyc++;
        end
    end

    // Compares every output of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            for (int i = 0; i < 2; i++) begin
                bit vis;
                vis = modelValid(i);
                checkVal($sformatf("dut%0d m_valid", i), DW'(mValid[i]), DW'(vis));
                if (vis) checkVal($sformatf("dut%0d m_data", i), mData[i], qData[i][qHead[i]]);
                checkVal($sformatf("dut%0d level", i), DW'(lvl[i]), DW'(qCnt[i]));
                checkVal($sformatf("dut%0d s_ready", i), DW'(sReady[i]), DW'(mRdy[i]));
                checkVal($sformatf("dut%0d almost_full", i), DW'(aFull[i]), DW'(qCnt[i] >= AFULL));
                checkVal($sformatf("dut%0d almost_empty", i), DW'(aEmpty[i]), DW'(qCnt[i] <= AEMPT));
                checkVal($sformatf("dut%0d ovf_cnt", i), DW'(ovf[i]), DW'(mOvf[i]));
            end
        end
    end

    // Drives one cycle of inputs, lets the edge consume them, and returns just after that edge.
    task automatic applyStimulus(input bit sv, input logic [DW-1:0] d, input bit mr, input bit fl);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkVal($sformatf("dut%0d %s", i, name), act, exp);
    endtask

    initial begin
        int exp0;
        int exp1;
        logic [95:0] rnd;

        #1 rst = 1'b1;
        cmpEn = 1'b1;
        #1;
        checkOutput("reset s_ready", 0, DW'(sReady[0]), DW'(0));
        checkOutput("reset level", 0, DW'(lvl[0]), DW'(0));
        checkOutput("reset almost_empty", 1, DW'(aEmpty[1]), DW'(1));
        checkOutput("reset m_valid", 1, DW'(mValid[1]), DW'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("s_ready before first edge", 0, DW'(sReady[0]), DW'(0));
        applyStimulus(0, '0, 0, 0);
        checkOutput("s_ready after release", 0, DW'(sReady[0]), DW'(1));
        checkOutput("s_ready after release", 1, DW'(sReady[1]), DW'(1));

        // Single word: direct read shows it one cycle after the push, registered output two.
        applyStimulus(1, DW'('h2A), 0, 0);
        checkOutput("t+1 m_valid", 0, DW'(mValid[0]), DW'(1));
        checkOutput("t+1 m_data", 0, mData[0], DW'('h2A));
        checkOutput("t+1 m_valid", 1, DW'(mValid[1]), DW'(0));
        checkOutput("t+1 level", 1, DW'(lvl[1]), DW'(1));
        applyStimulus(0, '0, 0, 0);
        checkOutput("t+2 m_valid", 1, DW'(mValid[1]), DW'(1));
        checkOutput("t+2 m_data", 1, mData[1], DW'('h2A));
        applyStimulus(0, '0, 1, 0);
        checkOutput("drained m_valid", 0, DW'(mValid[0]), DW'(0));
        checkOutput("drained level", 1, DW'(lvl[1]), DW'(0));

        // Fill with m_ready low: 16 words fit without the output stage, 17 with it.
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1, DW'(k), 0, 0);
            if (k == 12) checkOutput("almost_full at 13", 0, DW'(aFull[0]), DW'(0));
            if (k == 13) checkOutput("almost_full at 14", 0, DW'(aFull[0]), DW'(1));
            if (k == 15) begin
                checkOutput("s_ready after 16th", 0, DW'(sReady[0]), DW'(0));
                checkOutput("level after 16th", 0, DW'(lvl[0]), DW'(16));
                checkOutput("s_ready after 16th", 1, DW'(sReady[1]), DW'(1));
            end
        end
        checkOutput("full level", 1, DW'(lvl[1]), DW'(17));
        checkOutput("full s_ready", 1, DW'(sReady[1]), DW'(0));
        checkOutput("ovf after fill", 0, DW'(ovf[0]), DW'(1));
        for (int k = 0; k < 5; k++) applyStimulus(1, DW'('h3FF), 0, 0);
        checkOutput("ovf after 5 rejects", 1, DW'(ovf[1]), DW'(5));
        checkOutput("ovf after 6 rejects", 0, DW'(ovf[0]), DW'(6));
        checkOutput("level unchanged", 0, DW'(lvl[0]), DW'(16));

        // Drain everything and confirm strict ascending order.
        exp0 = 0;
        exp1 = 0;
        for (int k = 0; k < 20; k++) begin
            if (mValid[0]) begin
                checkOutput("drain order", 0, mData[0], DW'(exp0));
                exp0++;
            end
            if (mValid[1]) begin
                checkOutput("drain order", 1, mData[1], DW'(exp1));
                exp1++;
            end
            applyStimulus(0, '0, 1, 0);
        end
        checkOutput("words drained", 0, DW'(exp0), DW'(16));
        checkOutput("words drained", 1, DW'(exp1), DW'(17));

        // Hold level 8 with simultaneous push and pop; pointers wrap several times.
        for (int k = 0; k < 8; k++) applyStimulus(1, DW'(100 + k), 0, 0);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, DW'(200 + k), 1, 0);
            if (k % 10 == 9) begin
                checkOutput("steady level", 0, DW'(lvl[0]), DW'(8));
                checkOutput("steady level", 1, DW'(lvl[1]), DW'(8));
            end
        end
        checkOutput("steady head", 0, mData[0], DW'(232));

        // Flush with a push and pop pending: both are discarded and the counters clear.
        applyStimulus(1, DW'('h55), 1, 1);
        checkOutput("flush level", 0, DW'(lvl[0]), DW'(0));
        checkOutput("flush m_valid", 1, DW'(mValid[1]), DW'(0));
        checkOutput("flush ovf", 0, DW'(ovf[0]), DW'(0));
        applyStimulus(0, '0, 0, 0);

        // Asynchronous reset between edges with five words held.
        for (int k = 0; k < 5; k++) applyStimulus(1, DW'(300 + k), 0, 0);
        checkOutput("pre-reset level", 1, DW'(lvl[1]), DW'(5));
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset m_valid", 0, DW'(mValid[0]), DW'(0));
        checkOutput("async reset level", 0, DW'(lvl[0]), DW'(0));
        checkOutput("async reset m_valid", 1, DW'(mValid[1]), DW'(0));
        checkOutput("async reset level", 1, DW'(lvl[1]), DW'(0));
        #1 rst = 1'b0;
        applyStimulus(0, '0, 0, 0);
        checkOutput("s_ready after pulse", 0, DW'(sReady[0]), DW'(1));
        checkOutput("s_ready after pulse", 1, DW'(sReady[1]), DW'(1));

        // Mixed traffic with occasional flushes, checked entirely by the model.
        for (int k = 0; k < 300; k++) begin
            rnd = {$urandom, $urandom, $urandom};
            applyStimulus(($urandom % 4) != 0, rnd[DW-1:0], ($urandom % 3) != 0, ($urandom % 50) == 0);
        end
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        #1 cmpEn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
